leb128_decoder: RTL and testbench
=================================

Name: leb128_decoder

Overview:
- Byte-serial LEB128 immediate decoder between the genrom instruction stream and the cpu execute stage.
- Consumes one code byte per cycle and reassembles unsigned (u32/u64) or signed (s32/s64) WebAssembly immediates up to 64 bits.
- Presents each immediate with its encoded length so the fetch logic can advance the program counter.
- Raises a sticky error that the cpu maps to a trap on malformed encodings.

Parameters:
- WIDTH, 64, result width in bits.
- MAX_BYTES, 10, maximum encoded length; ceil(WIDTH/7).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-low reset; sampled on the clk rising edge.
- in_byte  input  8  next code byte from the ROM window.
- in_valid  input  1  in_byte is valid.
- in_ready  output  1  decoder accepts in_byte this cycle.
- signed_mode  input  1  1 = signed LEB128; sampled with the first byte only.
- out_value  output  WIDTH  decoded immediate; zero-extended if unsigned, sign-extended if signed.
- out_len  output  4  number of bytes consumed, 1..MAX_BYTES.
- out_valid  output  1  out_value and out_len are valid.
- out_ready  input  1  consumer takes the result.
- error  output  1  sticky malformed-encoding flag.

Behaviour:
- Reset (reset==0 at a clk edge):
  - state=IDLE; accumulator=0; count=0.
  - out_value=0, out_len=0, out_valid=0, error=0, in_ready=0 during the reset cycle.
  - Reset wins over every other event, including mid-decode; the partial value is discarded.
- Byte acceptance: a byte is accepted on a clk edge when in_valid && in_ready.
- State IDLE:
  - in_ready=1.
  - On accept: latch signed_mode; acc = in_byte[6:0]; count=1.
  - If in_byte[7]==1, go to ACCUM; otherwise finalize and go to DONE.
- State ACCUM:
  - in_ready=1.
  - On accept: acc |= in_byte[6:0] << (7*count), truncated to WIDTH; count++.
  - If in_byte[7]==0, finalize and go to DONE.
  - If in_byte[7]==1 and count reaches MAX_BYTES, go to ERROR.
- Finalize:
  - Signed mode, shift = 7*count < WIDTH, and last byte bit 6 == 1: bits [WIDTH-1:shift] of acc are set to 1.
  - out_len = count.
- State DONE:
  - out_valid=1, in_ready=0. out_value and out_len are stable while out_valid.
  - Latency: out_valid rises on the clk edge that accepts the final byte, so a 1-byte immediate is visible the next cycle.
  - On out_ready: go to IDLE, out_valid=0. No same-cycle accept of a new byte.
  - out_ready with out_valid==0 is ignored.
- State ERROR:
  - error=1, in_ready=0, out_valid=0.
  - Held until reset.
- in_valid low in any state: no state change. Gaps between bytes are allowed.
- Width rule: shifted bits beyond WIDTH are dropped unless the optional check below is enabled.

Optional Feature:
- Macro: LEB128_STRICT_EN.
- Defined: the final byte of a MAX_BYTES-long encoding is checked.
  - Unsigned: bits above WIDTH must be 0 (for 64-bit, the 10th byte must be 0x00 or 0x01).
  - Signed: those bits must equal the sign bit (10th byte 0x00 or 0x7F).
  - On violation: go to ERROR instead of DONE.
- Undefined: no check; excess bits are silently truncated.

Test Plan:
- Unsigned single byte: byte 0x2A -> out_value=42, out_len=1, out_valid one cycle after accept, error=0.
- Unsigned multi-byte: bytes 0xE5 0x8E 0x26 with a 2-cycle in_valid gap after the first -> out_value=624485, out_len=3.
- Signed:
  - 0x7F -> out_value=0xFFFF_FFFF_FFFF_FFFF, out_len=1.
  - 0xC0 0xBB 0x78 -> out_value=-123456, out_len=3.
- Overlong input: eleven bytes of 0x80 -> error=1 after the 10th accept, in_ready=0, out_valid stays 0 until reset; the next reset clears error to 0.
- Backpressure and reset:
  - Decode 0x05 with out_ready low for 3 cycles -> out_valid, out_value=5 and in_ready=0 hold.
  - Separately, pull reset low after byte 0x80 -> IDLE; 0x07 then decodes to 7, out_len=1.
- Strict check (LEB128_STRICT_EN only): unsigned 0xFF×9 then 0x02 -> error=1.
  - With the macro undefined, the same input yields out_len=10 and no error.

Source files
------------

// File: rtl/leb128_decoder_if.sv
// Byte-in / immediate-out handshake bundle for the LEB128 decoder; master is the fetch/execute side.
interface leb128_decoder_if #(
  parameter int WIDTH = 64
);
  logic [7:0]       in_byte;
  logic             in_valid;
  logic             in_ready;
  logic             signed_mode;
  logic [WIDTH-1:0] out_value;
  logic [3:0]       out_len;
  logic             out_valid;
  logic             out_ready;
  logic             error;

  modport master (
    output in_byte, in_valid, signed_mode, out_ready,
    input  in_ready, out_value, out_len, out_valid, error
  );

  modport slave (
    input  in_byte, in_valid, signed_mode, out_ready,
    output in_ready, out_value, out_len, out_valid, error
  );
endinterface

// File: rtl/leb128_decoder.sv
// Byte-serial LEB128 immediate decoder: result valid the cycle after the final byte, held (in_ready low) until out_ready.
// Macro LEB128_STRICT_EN rejects excess bits in a MAX_BYTES-long encoding; sticky error state until reset.
module leb128_decoder #(
  parameter int WIDTH     = 64,
  parameter int MAX_BYTES = 10
) (
  input logic             clk,
  input logic             reset,
  leb128_decoder_if.slave bus
);

  localparam int SHW = $clog2(7 * MAX_BYTES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCUM,
    S_DONE,
    S_ERROR
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [WIDTH-1:0] r_acc, w_acc_nxt;
  logic [3:0]       r_count, w_count_nxt;
  logic             r_signed, w_signed_nxt;

  logic             w_can_take;
  logic             w_accept;
  logic             w_first;
  logic [3:0]       w_count_inc;
  logic             w_signed_cur;
  logic [SHW-1:0]   w_shift;
  logic [SHW-1:0]   w_shift_end;
  logic [WIDTH-1:0] w_part;
  logic [WIDTH-1:0] w_merged;
  logic [WIDTH-1:0] w_final;
  logic             w_last;
  logic             w_overlong;
  logic             w_strict_bad;

  assign w_can_take = reset && ((r_state == S_IDLE) || (r_state == S_ACCUM));
  assign w_accept   = bus.in_valid && w_can_take;
  assign w_first    = (r_state == S_IDLE);

  // Datapath: merge the incoming 7-bit group and build the finalized value.
  always_comb begin
    w_count_inc  = w_first ? 4'd1 : (r_count + 4'd1);
    w_signed_cur = w_first ? bus.signed_mode : r_signed;
    w_shift      = w_first ? '0 : (SHW'(r_count) * SHW'(7));
    w_shift_end  = SHW'(w_count_inc) * SHW'(7);
    w_part       = {{(WIDTH-7){1'b0}}, bus.in_byte[6:0]} << w_shift;
    w_merged     = (w_first ? '0 : r_acc) | w_part;
    w_final      = w_merged;
    // Sign-extend only when the sign bit lands inside the result width.
    if (w_signed_cur && (int'(w_shift_end) < WIDTH) && bus.in_byte[6]) begin
      w_final = w_merged | ({WIDTH{1'b1}} << w_shift_end);
    end
    w_last     = !bus.in_byte[7];
    w_overlong = bus.in_byte[7] && (w_count_inc == 4'(MAX_BYTES));
  end

`ifdef LEB128_STRICT_EN
  localparam int         LAST_USED   = WIDTH - 7 * (MAX_BYTES - 1);
  localparam logic [6:0] EXCESS_MASK = 7'(7'h7F << LAST_USED);

  // Bits of the last group above WIDTH must be zero (unsigned) or copies of the sign bit.
  always_comb begin
    w_strict_bad = 1'b0;
    if (w_count_inc == 4'(MAX_BYTES)) begin
      w_strict_bad = (bus.in_byte[6:0] & EXCESS_MASK) !=
                     ((w_signed_cur && bus.in_byte[LAST_USED-1]) ? EXCESS_MASK : 7'd0);
    end
  end
`else
  assign w_strict_bad = 1'b0;
`endif

  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc;
    w_count_nxt  = r_count;
    w_signed_nxt = r_signed;
    case (r_state)
      S_IDLE, S_ACCUM: begin
        if (w_accept) begin
          w_count_nxt  = w_count_inc;
          w_signed_nxt = w_signed_cur;
          if (w_last) begin
            w_acc_nxt   = w_final;
            w_state_nxt = w_strict_bad ? S_ERROR : S_DONE;
          end else begin
            w_acc_nxt   = w_merged;
            w_state_nxt = w_overlong ? S_ERROR : S_ACCUM;
          end
        end
      end
      S_DONE: begin
        if (bus.out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ERROR: begin
        w_state_nxt = S_ERROR;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      r_acc    <= '0;
      r_count  <= '0;
      r_signed <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_acc    <= w_acc_nxt;
      r_count  <= w_count_nxt;
      r_signed <= w_signed_nxt;
    end
  end

  assign bus.in_ready  = w_can_take;
  assign bus.out_value = r_acc;
  assign bus.out_len   = r_count;
  assign bus.out_valid = (r_state == S_DONE);
  assign bus.error     = (r_state == S_ERROR);

endmodule

// File: tb/tb_leb128_decoder.sv
// Directed bench for leb128_decoder with a result scoreboard; build with or without LEB128_STRICT_EN.
module tb_leb128_decoder;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  leb128_decoder_if #(.WIDTH(64)) bus ();

  leb128_decoder #(
    .WIDTH    (64),
    .MAX_BYTES(10)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  typedef struct packed {
    logic [63:0] value;
    logic [3:0]  len;
  } res_t;

  res_t sb[$];
  int   total  = 0;
  int   passed = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a byte until the decoder takes it; returns just after the accepting edge.
  task automatic send(input logic [7:0] b, input logic sm);
    int guard;
    logic timed_out;
    guard = 0;
    timed_out = 1'b0;
    bus.in_byte     = b;
    bus.signed_mode = sm;
    bus.in_valid    = 1'b1;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      guard++;
      if (guard > 50) begin
        timed_out = 1'b1;
        break;
      end
    end
    if (timed_out) chk("send_timeout", {63'd0, timed_out}, 64'd0);
    else begin
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_res(input logic [63:0] v, input logic [3:0] l);
    res_t r;
    r.value = v;
    r.len   = l;
    sb.push_back(r);
  endtask

  // Scoreboard monitor: every completed handshake must match the oldest expected result.
  always @(negedge clk) begin : mon
    res_t e;
    if (reset && bus.out_valid && bus.out_ready) begin
      chk("unexpected_result", {63'd0, sb.size() == 0}, 64'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("out_value", bus.out_value, e.value);
        chk("out_len", {60'd0, bus.out_len}, {60'd0, e.len});
      end
    end
  end

  initial begin
    bus.in_byte     = 8'h00;
    bus.in_valid    = 1'b0;
    bus.signed_mode = 1'b0;
    bus.out_ready   = 1'b0;

    // Reset state
    cycles(3);
    @(negedge clk);
    chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
    chk("rst_error", {63'd0, bus.error}, 64'd0);
    chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("rst_out_len", {60'd0, bus.out_len}, 64'd0);
    chk("rst_out_value", bus.out_value, 64'd0);
    @(posedge clk);
    #1;
    reset         = 1'b1;
    bus.out_ready = 1'b1;
    #1;
    chk("idle_in_ready", {63'd0, bus.in_ready}, 64'd1);

    // Unsigned single byte, one-cycle latency
    expect_res(64'd42, 4'd1);
    send(8'h2A, 1'b0);
    chk("single_latency_valid", {63'd0, bus.out_valid}, 64'd1);
    chk("single_in_ready_low", {63'd0, bus.in_ready}, 64'd0);
    chk("single_error", {63'd0, bus.error}, 64'd0);
    cycles(2);

    // Unsigned multi-byte with a gap
    expect_res(64'd624485, 4'd3);
    send(8'hE5, 1'b0);
    cycles(2);
    send(8'h8E, 1'b0);
    send(8'h26, 1'b0);
    cycles(2);

    // Signed
    expect_res(64'hFFFF_FFFF_FFFF_FFFF, 4'd1);
    send(8'h7F, 1'b1);
    cycles(2);
    expect_res(64'hFFFF_FFFF_FFFE_1DC0, 4'd3);
    send(8'hC0, 1'b1);
    send(8'hBB, 1'b0);
    send(8'h78, 1'b0);
    cycles(2);

    // Backpressure: result held while out_ready is low
    bus.out_ready = 1'b0;
    send(8'h05, 1'b0);
    bus.in_byte  = 8'h33;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
      chk("bp_out_value", bus.out_value, 64'd5);
      chk("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    expect_res(64'd5, 4'd1);
    bus.out_ready = 1'b1;
    cycles(3);

    // Reset mid-decode discards the partial value
    send(8'h85, 1'b0);
    reset = 1'b0;
    @(negedge clk);
    chk("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    chk("midrst_acc_cleared", bus.out_value, 64'd0);
    chk("midrst_len_cleared", {60'd0, bus.out_len}, 64'd0);
    expect_res(64'd7, 4'd1);
    send(8'h07, 1'b0);
    cycles(2);

    // Maximum-length encodings that are in range
    expect_res(64'hFFFF_FFFF_FFFF_FFFF, 4'd10);
    for (int i = 0; i < 9; i++) send(8'hFF, 1'b0);
    send(8'h01, 1'b0);
    cycles(2);
    expect_res(64'hFFFF_FFFF_FFFF_FFFF, 4'd10);
    for (int i = 0; i < 9; i++) send(8'hFF, 1'b1);
    send(8'h7F, 1'b1);
    cycles(2);

    // Excess bits in the tenth byte
`ifdef LEB128_STRICT_EN
    for (int i = 0; i < 9; i++) send(8'hFF, 1'b0);
    send(8'h02, 1'b0);
    chk("strict_error", {63'd0, bus.error}, 64'd1);
    chk("strict_out_valid", {63'd0, bus.out_valid}, 64'd0);
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
`else
    expect_res(64'h7FFF_FFFF_FFFF_FFFF, 4'd10);
    for (int i = 0; i < 9; i++) send(8'hFF, 1'b0);
    send(8'h02, 1'b0);
    chk("trunc_no_error", {63'd0, bus.error}, 64'd0);
    cycles(2);
`endif

    // Overlong: ten continuation bytes
    for (int i = 0; i < 10; i++) send(8'h80, 1'b0);
    chk("ovl_error", {63'd0, bus.error}, 64'd1);
    chk("ovl_in_ready", {63'd0, bus.in_ready}, 64'd0);
    chk("ovl_out_valid", {63'd0, bus.out_valid}, 64'd0);
    bus.in_byte  = 8'h80;
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ovl_error_sticky", {63'd0, bus.error}, 64'd1);
      chk("ovl_out_valid_hold", {63'd0, bus.out_valid}, 64'd0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    reset = 1'b0;
    cycles(1);
    reset = 1'b1;
    #1;
    chk("ovl_error_cleared", {63'd0, bus.error}, 64'd0);
    chk("ovl_in_ready_back", {63'd0, bus.in_ready}, 64'd1);

    // Drain scoreboard
    for (int i = 0; i < 20 && sb.size() != 0; i++) cycles(1);
    chk("sb_drain", 64'(sb.size()), 64'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
